// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared MIPS opcodes, ALU op codes, mux selects and multi-cycle states
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;
    localparam logic [2:0] ALU_OP_OR    = 3'b101;
    localparam logic [2:0] ALU_OP_LUI   = 3'b110;
    localparam logic [2:0] ALU_OP_SUB   = 3'b011;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] MEMTO_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTO_MDR    = 2'b01;
    localparam logic [1:0] MEMTO_PC     = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        I_EXEC    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13,
        TRAP      = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_JR,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_instr_class_decoder.sv
// rtl/multicycle_control_instr_class_decoder.sv - op/funct to instruction class, I-type alu_op and shamt flag
module instr_class_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output logic [2:0]   o_i_alu_op,
    output logic         o_shamt
);

    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_i_alu_op = ALU_OP_ADD;
        o_shamt    = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_class = (i_funct == FUNCT_JR) ? CLS_JR : CLS_R;
                o_shamt = (i_funct == FUNCT_SLL) || (i_funct == FUNCT_SRL);
            end
            OP_ADDI: o_class = CLS_I;
            OP_ORI: begin
                o_class    = CLS_I;
                o_i_alu_op = ALU_OP_OR;
            end
            OP_LUI: begin
                o_class    = CLS_I;
                o_i_alu_op = ALU_OP_LUI;
            end
            OP_LW:   o_class = CLS_LW;
            OP_SW:   o_class = CLS_SW;
            OP_BEQ:  o_class = CLS_BEQ;
            OP_BNE:  o_class = CLS_BNE;
            OP_J:    o_class = CLS_J;
            OP_JAL:  o_class = CLS_JAL;
            default: o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencer sharing one ALU and one memory
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           memto_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 shamt_sel,
    output logic [2:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 illegal_op,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    instr_class_t           w_class;
    logic [2:0]             w_i_alu_op;
    logic                   w_shamt;

    instr_class_decoder u_decoder (
        .i_op       (op),
        .i_funct    (funct),
        .o_class    (w_class),
        .o_i_alu_op (w_i_alu_op),
        .o_shamt    (w_shamt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (retire) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign retired_cnt = r_cnt;

    // IR holds the current instruction from DECODE onwards, so op/funct stay valid in later states
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = REG_DST_RT;
        memto_reg    = MEMTO_ALUOUT;
        alu_src_a    = 1'b0;
        alu_src_b    = ALU_B_RT;
        shamt_sel    = 1'b0;
        alu_op       = 3'b000;
        pc_source    = PC_SRC_ALU;
        illegal_op   = 1'b0;
        retire       = 1'b0;
        case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_B_FOUR;
                alu_op    = ALU_OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next_state = DECODE;
            end
            DECODE: begin
                alu_src_b = ALU_B_IMM_SH2;
                alu_op    = ALU_OP_ADD;
                case (w_class)
                    CLS_R:           w_next_state = R_EXEC;
                    CLS_JR:          w_next_state = JR;
                    CLS_I:           w_next_state = I_EXEC;
                    CLS_LW, CLS_SW:  w_next_state = MEM_ADDR;
                    CLS_BEQ, CLS_BNE: w_next_state = BRANCH;
                    CLS_J:           w_next_state = JUMP;
                    CLS_JAL:         w_next_state = JAL;
                    default:         w_next_state = TRAP;
                endcase
            end
            R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ALU_B_RT;
                alu_op       = ALU_OP_RTYPE;
                shamt_sel    = w_shamt;
                w_next_state = R_WB;
            end
            R_WB: begin
                reg_write    = 1'b1;
                reg_dst      = REG_DST_RD;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ALU_B_IMM;
                alu_op       = w_i_alu_op;
                w_next_state = I_WB;
            end
            I_WB: begin
                reg_write    = 1'b1;
                reg_dst      = REG_DST_RT;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ALU_B_IMM;
                alu_op       = ALU_OP_ADD;
                w_next_state = (w_class == CLS_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) w_next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write    = 1'b1;
                memto_reg    = MEMTO_MDR;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
                if (mem_ready) w_next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ALU_B_RT;
                alu_op       = ALU_OP_SUB;
                pc_source    = PC_SRC_ALUOUT;
                pc_write     = (w_class == CLS_BNE) ? !zero : zero;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            JUMP: begin
                pc_write     = 1'b1;
                pc_source    = PC_SRC_JUMP;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            JAL: begin
                reg_write    = 1'b1;
                reg_dst      = REG_DST_RA;
                memto_reg    = MEMTO_PC;
                pc_write     = 1'b1;
                pc_source    = PC_SRC_JUMP;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            JR: begin
                pc_write     = 1'b1;
                pc_source    = PC_SRC_RS;
                retire       = 1'b1;
                w_next_state = FETCH;
            end
            TRAP: begin
                illegal_op   = 1'b1;
                w_next_state = TRAP;
            end
            default: w_next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       shamt_sel;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       retire;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, memto_reg, alu_src_b, pc_source;
    logic       alu_src_a, shamt_sel, illegal_op, retire;
    logic [2:0] alu_op;
    logic [3:0] retired_cnt;

    ctl_t       act;
    exp_t       q[$];
    logic [3:0] exp_cnt = 4'd0;
    int         checks = 0;
    int         failures = 0;

    multicycle_control #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .memto_reg(memto_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .shamt_sel(shamt_sel),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .retire(retire), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, memto_reg, alu_src_a, alu_src_b, shamt_sel,
                  alu_op, pc_source, illegal_op, retire};

    function automatic ctl_t mk(input logic pw, io, mr, mw, irw, rw,
                                input logic [1:0] rd, mtr, input logic asa,
                                input logic [1:0] asb, input logic sh,
                                input logic [2:0] aop, input logic [1:0] pcs,
                                input logic ill, ret);
        return {pw, io, mr, mw, irw, rw, rd, mtr, asa, asb, sh, aop, pcs, ill, ret};
    endfunction

    //                        pw io mr mw ir rw rd     mtr    a  b      sh aop     pcs    il rt
    ctl_t E_FETCH_W = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 3'b100, 2'b00, 0, 0);
    ctl_t E_FETCH   = mk(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 0, 3'b100, 2'b00, 0, 0);
    ctl_t E_DECODE  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 3'b100, 2'b00, 0, 0);
    ctl_t E_REXEC   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 3'b111, 2'b00, 0, 0);
    ctl_t E_REXEC_S = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 1, 3'b111, 2'b00, 0, 0);
    ctl_t E_RWB     = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 1);
    ctl_t E_IEXEC_O = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 3'b101, 2'b00, 0, 0);
    ctl_t E_IWB     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 1);
    ctl_t E_MADDR   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 3'b100, 2'b00, 0, 0);
    ctl_t E_MREAD   = mk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
    ctl_t E_MWB     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 0, 3'b000, 2'b00, 0, 1);
    ctl_t E_MWRITE_W= mk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
    ctl_t E_MWRITE  = mk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 1);
    ctl_t E_BR_T    = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 3'b011, 2'b01, 0, 1);
    ctl_t E_BR_N    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 3'b011, 2'b01, 0, 1);
    ctl_t E_JUMP    = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b10, 0, 1);
    ctl_t E_JAL     = mk(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 3'b000, 2'b10, 0, 1);
    ctl_t E_JR      = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b11, 0, 1);
    ctl_t E_TRAP    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0);

    // One expectation per cycle; the monitor consumes it on the falling edge
    task automatic step(input string nm, input logic [5:0] o, f,
                        input logic z, rdy, input ctl_t e);
        exp_t x;
        op = o; funct = f; zero = z; mem_ready = rdy;
        x.c = e; x.cnt = exp_cnt; x.name = nm;
        q.push_back(x);
        @(posedge clk);
        if (e.retire) exp_cnt = exp_cnt + 4'd1;
        #1;
    endtask

    task automatic rst_step(input string nm, input logic rv, rdy, input ctl_t e);
        exp_t x;
        reset = rv; mem_ready = rdy;
        if (!rv) exp_cnt = 4'd0;
        x.c = e; x.cnt = exp_cnt; x.name = nm;
        q.push_back(x);
        @(posedge clk);
        if (rv && e.retire) exp_cnt = exp_cnt + 4'd1;
        #1;
    endtask

    task automatic do_j(input string nm);
        step({nm, "_fetch"}, 6'h02, 6'h00, 0, 1, E_FETCH);
        step({nm, "_decode"}, 6'h02, 6'h00, 0, 1, E_DECODE);
        step({nm, "_jump"}, 6'h02, 6'h00, 0, 1, E_JUMP);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (act !== x.c) begin
                    failures++;
                    $display("FAIL %s ctl actual=%06h required=%06h", x.name, act, x.c);
                end
                checks++;
                if (retired_cnt !== x.cnt) begin
                    failures++;
                    $display("FAIL %s retired_cnt actual=%0d required=%0d", x.name, retired_cnt, x.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        @(posedge clk); #1;
        rst_step("reset_hold", 0, 0, E_FETCH_W);

        rst_step("add_fetch_wait", 1, 0, E_FETCH_W);
        step("add_fetch", 6'h00, 6'h20, 0, 1, E_FETCH);
        step("add_decode", 6'h00, 6'h20, 0, 1, E_DECODE);
        step("add_rexec", 6'h00, 6'h20, 0, 1, E_REXEC);
        step("add_rwb", 6'h00, 6'h20, 0, 1, E_RWB);

        step("sll_fetch", 6'h00, 6'h00, 0, 1, E_FETCH);
        step("sll_decode", 6'h00, 6'h00, 0, 1, E_DECODE);
        step("sll_rexec", 6'h00, 6'h00, 0, 1, E_REXEC_S);
        step("sll_rwb", 6'h00, 6'h00, 0, 1, E_RWB);

        step("lw_fetch", 6'h23, 6'h00, 0, 1, E_FETCH);
        step("lw_decode", 6'h23, 6'h00, 0, 1, E_DECODE);
        step("lw_maddr", 6'h23, 6'h00, 0, 1, E_MADDR);
        step("lw_mread_w1", 6'h23, 6'h00, 0, 0, E_MREAD);
        step("lw_mread_w2", 6'h23, 6'h00, 0, 0, E_MREAD);
        step("lw_mread", 6'h23, 6'h00, 0, 1, E_MREAD);
        step("lw_mwb", 6'h23, 6'h00, 0, 1, E_MWB);

        step("ori_fetch", 6'h0d, 6'h00, 0, 1, E_FETCH);
        step("ori_decode", 6'h0d, 6'h00, 0, 1, E_DECODE);
        step("ori_iexec", 6'h0d, 6'h00, 0, 1, E_IEXEC_O);
        step("ori_iwb", 6'h0d, 6'h00, 0, 1, E_IWB);

        step("beq_t_fetch", 6'h04, 6'h00, 1, 1, E_FETCH);
        step("beq_t_decode", 6'h04, 6'h00, 1, 1, E_DECODE);
        step("beq_t_branch", 6'h04, 6'h00, 1, 1, E_BR_T);
        step("beq_n_fetch", 6'h04, 6'h00, 0, 1, E_FETCH);
        step("beq_n_decode", 6'h04, 6'h00, 0, 1, E_DECODE);
        step("beq_n_branch", 6'h04, 6'h00, 0, 1, E_BR_N);
        step("bne_fetch", 6'h05, 6'h00, 0, 1, E_FETCH);
        step("bne_decode", 6'h05, 6'h00, 0, 1, E_DECODE);
        step("bne_branch", 6'h05, 6'h00, 0, 1, E_BR_T);

        do_j("j0");
        step("jal_fetch", 6'h03, 6'h00, 0, 1, E_FETCH);
        step("jal_decode", 6'h03, 6'h00, 0, 1, E_DECODE);
        step("jal_jal", 6'h03, 6'h00, 0, 1, E_JAL);
        step("jr_fetch_w", 6'h00, 6'h08, 0, 0, E_FETCH_W);
        step("jr_fetch", 6'h00, 6'h08, 0, 1, E_FETCH);
        step("jr_decode", 6'h00, 6'h08, 0, 1, E_DECODE);
        step("jr_jr", 6'h00, 6'h08, 0, 1, E_JR);

        step("sw_fetch", 6'h2b, 6'h00, 0, 1, E_FETCH);
        step("sw_decode", 6'h2b, 6'h00, 0, 1, E_DECODE);
        step("sw_maddr", 6'h2b, 6'h00, 0, 1, E_MADDR);
        step("sw_mwrite", 6'h2b, 6'h00, 0, 1, E_MWRITE);

        // 11 retired so far; six more wrap the 4-bit counter through 15 -> 0 -> 1
        do_j("j1"); do_j("j2"); do_j("j3"); do_j("j4"); do_j("j5"); do_j("j6");

        step("swr_fetch", 6'h2b, 6'h00, 0, 1, E_FETCH);
        step("swr_decode", 6'h2b, 6'h00, 0, 1, E_DECODE);
        step("swr_maddr", 6'h2b, 6'h00, 0, 1, E_MADDR);
        step("swr_mwrite_w", 6'h2b, 6'h00, 0, 0, E_MWRITE_W);
        rst_step("swr_async_reset", 0, 0, E_FETCH_W);
        rst_step("swr_release", 1, 1, E_FETCH);

        step("add2_decode", 6'h00, 6'h20, 0, 1, E_DECODE);
        step("add2_rexec", 6'h00, 6'h20, 0, 1, E_REXEC);
        step("add2_rwb", 6'h00, 6'h20, 0, 1, E_RWB);

        step("ill_fetch", 6'h3f, 6'h00, 0, 1, E_FETCH);
        step("ill_decode", 6'h3f, 6'h00, 0, 1, E_DECODE);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("ill_trap%0d", i), 6'h3f, 6'h00, i[0], i[1], E_TRAP);
        end
        rst_step("ill_reset", 0, 0, E_FETCH_W);
        rst_step("ill_release", 1, 0, E_FETCH_W);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath. Replaces per-instruction combinational decode with an FSM that shares one ALU and one unified memory across fetch, execute and memory phases.
- Instruction set: R-type (including sll, srl, jr), addi, ori, lui, lw, sw, beq, bne, j, jal.
- Sits between the instruction register and the datapath mux/enable inputs.
- Stalls on a memory ready handshake.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the access this cycle
- pc_write  output  1  PC load enable
- iord  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_write  output  1  register file write enable
- reg_dst  output  2  destination register: 00 rt, 01 rd, 10 $ra
- memto_reg  output  2  write-back data: 00 ALUOut, 01 MDR, 10 PC
- alu_src_a  output  1  ALU A input: 0 PC, 1 rs
- alu_src_b  output  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- shamt_sel  output  1  ALU A input takes shamt (sll/srl)
- alu_op  output  3  111 R-type (funct), 100 add, 101 or, 110 lui, 011 sub
- pc_source  output  2  PC next: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- illegal_op  output  1  sticky trap flag
- retire  output  1  one-cycle pulse when an instruction completes
- retired_cnt  output  CNT_WIDTH  count of retired instructions

Behaviour:
- Reset: reset low forces state FETCH, retired_cnt = 0 and illegal_op = 0 immediately. Reset is allowed mid-instruction; pending writes are dropped. All outputs not listed here are 0 in FETCH while mem_ready = 0.
- Outputs: all outputs are Moore functions of state, except where a line below marks a term with mem_ready or zero.
- FETCH:
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 100, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Holds while mem_ready = 0; moves to DECODE when mem_ready = 1.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = 100 (branch target into ALUOut).
  - Next state by op: 0x00 with funct 0x08 → JR; other 0x00 → R_EXEC; 0x08/0x0d/0x0f → I_EXEC; 0x23/0x2b → MEM_ADDR; 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x03 → JAL; anything else → TRAP.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 111; shamt_sel = 1 if funct is 0x00 or 0x02. Next state R_WB.
- R_WB: reg_write = 1, reg_dst = 01, memto_reg = 00, retire. Next state FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10; alu_op = 100 for addi, 101 for ori, 110 for lui. Next state I_WB.
- I_WB: reg_write = 1, reg_dst = 00, memto_reg = 00, retire. Next state FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 100. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, iord = 1. Holds until mem_ready = 1, then MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 00, memto_reg = 01, retire. Next state FETCH.
- MEM_WRITE: mem_write = 1, iord = 1. Holds until mem_ready = 1; retire in that same cycle. Next state FETCH.
- BRANCH:
  - Drives alu_src_a = 1, alu_src_b = 00, alu_op = 011, pc_source = 01, retire.
  - pc_write = zero for beq, !zero for bne. Next state FETCH.
- JUMP: pc_write = 1, pc_source = 10, retire. Next state FETCH.
- JAL: reg_write = 1, reg_dst = 10, memto_reg = 10 (PC already incremented, so PC+4), pc_write = 1, pc_source = 10, retire. Next state FETCH.
- JR: pc_write = 1, pc_source = 11, retire. Next state FETCH.
- TRAP: illegal_op = 1; all write enables 0. Stays in TRAP until reset.
- Counter: retired_cnt increments by 1 on each retire cycle and wraps from all-ones to 0.
- Mutual exclusion: mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Latency at zero memory wait states:
  - 3 cycles: branch, j, jal, jr.
  - 4 cycles: R-type, I-type ALU.
  - 4 cycles: sw.
  - 5 cycles: lw.
  - Each cycle with mem_ready = 0 adds one cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct localparams, shared with the single-cycle decoder;
  - alu_op encodings;
  - the 4-bit state enumeration: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9, BRANCH = 10, JUMP = 11, JAL = 12, JR = 13, TRAP = 14;
  - the reg_dst, memto_reg and pc_source select codes.
- One sub-module: instr_class_decoder, combinational, maps op/funct to instruction class, the I-type alu_op and the shamt flag.

Test Plan:
- add ($1 = $2 + $3), mem_ready tied 1 → states FETCH, DECODE, R_EXEC, R_WB; reg_write = 1 with reg_dst = 01 in cycle 4; retire pulse; retired_cnt = 1.
- lw with mem_ready low for 2 cycles in MEM_READ → mem_read and iord held at 1 for 3 cycles; MEM_WB has memto_reg = 01; total 7 cycles.
- beq with zero = 1, then beq with zero = 0 → BRANCH cycle has pc_write = 1 then 0; pc_source = 01 and alu_op = 011 in both.
- jal → JAL cycle has reg_write = 1, reg_dst = 10, memto_reg = 10, pc_write = 1, pc_source = 10; latency 3 cycles.
- op = 0x3f → TRAP after DECODE; illegal_op = 1 is sticky; no write enables for 10 cycles; reset low → illegal_op = 0 and state FETCH.
- sw with reset asserted in MEM_WRITE while mem_ready = 0 → mem_write drops to 0 asynchronously; retired_cnt = 0; after release, FETCH with mem_read = 1.
